// File: rtl/veda_wb_queue.sv
// veda_wb_queue: in-order pending-write queue that drains into the register file write port
// and offers youngest-match hazard lookup for two read indices.
module veda_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic              in_itype,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wb_hold,
    input  logic              flush,
    output logic              rf_write_enable,
    output logic              rf_instruction_check,
    output logic [ADDR_W-1:0] rf_rt,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_WriteData,
    input  logic [ADDR_W-1:0] q_rs,
    input  logic [ADDR_W-1:0] q_rt,
    output logic              q_rs_hit,
    output logic              q_rt_hit,
    output logic [DATA_W-1:0] q_rs_data,
    output logic [DATA_W-1:0] q_rt_data,
    output logic [LW-1:0]     level
);
    logic [ADDR_W-1:0] reg_q   [DEPTH];
    logic              itype_q [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, idx;
    logic              push, pop;

    assign in_ready = level < LW'(DEPTH);
    // Writes to register 0 complete the handshake but are dropped here.
    assign push = in_valid && in_ready && !flush && (in_reg != '0);
    assign pop  = rst_n && (level != '0) && !wb_hold && !flush;

    assign rf_write_enable      = pop;
    assign rf_instruction_check = pop && itype_q[rd_ptr];
    assign rf_rt                = (pop && itype_q[rd_ptr])  ? reg_q[rd_ptr] : '0;
    assign rf_rd                = (pop && !itype_q[rd_ptr]) ? reg_q[rd_ptr] : '0;
    assign rf_WriteData         = pop ? data_q[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[wr_ptr]   <= in_reg;
            itype_q[wr_ptr] <= in_itype;
            data_q[wr_ptr]  <= in_data;
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        q_rs_hit  = 1'b0;
        q_rt_hit  = 1'b0;
        q_rs_data = '0;
        q_rt_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (LW'(i) < level && q_rs != '0 && reg_q[idx] == q_rs) begin
                q_rs_hit  = 1'b1;
                q_rs_data = data_q[idx];
            end
            if (LW'(i) < level && q_rt != '0 && reg_q[idx] == q_rt) begin
                q_rt_hit  = 1'b1;
                q_rt_data = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_veda_wb_queue.sv
// tb_veda_wb_queue: directed checks of enqueue, drain order, hold, hazard lookup,
// register-0 drop, flush and mid-drain reset.
module tb_veda_wb_queue;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_itype, wb_hold, flush;
    logic [4:0]  in_reg, rf_rt, rf_rd, q_rs, q_rt;
    logic [31:0] in_data, rf_WriteData, q_rs_data, q_rt_data;
    logic        rf_write_enable, rf_instruction_check, q_rs_hit, q_rt_hit;
    logic [2:0]  level;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    veda_wb_queue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_itype(in_itype), .in_data(in_data),
        .wb_hold(wb_hold), .flush(flush), .rf_write_enable(rf_write_enable),
        .rf_instruction_check(rf_instruction_check), .rf_rt(rf_rt), .rf_rd(rf_rd),
        .rf_WriteData(rf_WriteData), .q_rs(q_rs), .q_rt(q_rt),
        .q_rs_hit(q_rs_hit), .q_rt_hit(q_rt_hit), .q_rs_data(q_rs_data),
        .q_rt_data(q_rt_data), .level(level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_reg = 0; in_itype = 0; in_data = 0;
        wb_hold = 0; flush = 0; q_rs = 0; q_rt = 0;
        tick(); tick();
        rst_n = 1; q_rs = 9; settle();
        chk("rst_level", level, 0);
        chk("rst_we", rf_write_enable, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_hit", q_rs_hit, 0);
        chk("rst_wd", rf_WriteData, 0);

        in_valid = 1; in_reg = 9; in_itype = 0; in_data = 32'hDEADBEEF; settle();
        chk("t1_ready", in_ready, 1);
        chk("t1_we_empty", rf_write_enable, 0);
        tick(); in_valid = 0; settle();
        chk("t1_we", rf_write_enable, 1);
        chk("t1_rd", rf_rd, 9);
        chk("t1_rt", rf_rt, 0);
        chk("t1_ic", rf_instruction_check, 0);
        chk("t1_wd", rf_WriteData, 32'hDEADBEEF);
        chk("t1_level", level, 1);
        chk("t1_hit_head", q_rs_hit, 1);
        chk("t1_hit_data", q_rs_data, 32'hDEADBEEF);
        tick(); settle();
        chk("t1_level_after", level, 0);
        chk("t1_we_after", rf_write_enable, 0);

        wb_hold = 1;
        for (int r = 1; r <= 4; r++) begin
            in_valid = 1; in_reg = 5'(r); in_itype = r[0]; in_data = 32'h100 + r;
            tick();
        end
        in_valid = 0; settle();
        chk("t2_full_level", level, 4);
        chk("t2_full_ready", in_ready, 0);
        chk("t2_hold_we", rf_write_enable, 0);
        in_valid = 1; in_reg = 5; in_itype = 0; in_data = 32'h105; tick();
        in_valid = 0; settle();
        chk("t2_no_fifth", level, 4);
        wb_hold = 0;
        for (int r = 1; r <= 4; r++) begin
            settle();
            chk("t2_we", rf_write_enable, 1);
            chk("t2_ic", rf_instruction_check, r[0]);
            chk("t2_rt", rf_rt, r[0] ? r : 0);
            chk("t2_rd", rf_rd, r[0] ? 0 : r);
            chk("t2_wd", rf_WriteData, 32'h100 + r);
            tick();
        end
        settle();
        chk("t2_empty", level, 0);
        chk("t2_we_empty", rf_write_enable, 0);

        in_valid = 1; in_reg = 10; in_itype = 0; in_data = 32'hA; tick();
        in_reg = 11; in_data = 32'hB; settle();
        chk("t2b_drain10", rf_rd, 10);
        tick(); in_valid = 0; settle();
        chk("t2b_level_same", level, 1);
        chk("t2b_drain11", rf_rd, 11);
        tick(); settle();
        chk("t2b_empty", level, 0);

        wb_hold = 1;
        in_valid = 1; in_reg = 7; in_itype = 1; in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        in_reg = 8; in_data = 32'h33; q_rs = 7; q_rt = 8; settle();
        chk("t3_rs_hit", q_rs_hit, 1);
        chk("t3_rs_youngest", q_rs_data, 32'h22);
        chk("t3_rt_inflight", q_rt_hit, 0);
        chk("t3_rt_data", q_rt_data, 0);
        tick(); in_valid = 0; settle();
        chk("t3_rt_hit_now", q_rt_hit, 1);
        chk("t3_rt_data_now", q_rt_data, 32'h33);
        chk("t3_level", level, 3);

        wb_hold = 0; flush = 1; in_valid = 1; in_reg = 12; in_data = 32'hC; settle();
        chk("t5_flush_we", rf_write_enable, 0);
        tick(); flush = 0; in_valid = 0; settle();
        chk("t5_flush_level", level, 0);
        chk("t5_flush_we_after", rf_write_enable, 0);
        chk("t5_flush_hit", q_rs_hit, 0);
        tick(); settle();
        chk("t5_flush_quiet", rf_write_enable, 0);

        in_valid = 1; in_reg = 0; in_data = 32'h55; settle();
        chk("t4_r0_ready", in_ready, 1);
        tick(); in_valid = 0; settle();
        chk("t4_r0_level", level, 0);
        chk("t4_r0_we", rf_write_enable, 0);

        wb_hold = 1; q_rs = 3;
        in_valid = 1; in_reg = 3; in_itype = 0; in_data = 32'h3; tick();
        in_reg = 4; in_data = 32'h4; tick();
        in_valid = 0; wb_hold = 0; settle();
        chk("t6_pending_we", rf_write_enable, 1);
        rst_n = 0; settle();
        chk("t6_rst_we", rf_write_enable, 0);
        tick(); rst_n = 1; settle();
        chk("t6_level", level, 0);
        chk("t6_we", rf_write_enable, 0);
        chk("t6_rd", rf_rd, 0);
        chk("t6_wd", rf_WriteData, 0);
        chk("t6_hit", q_rs_hit, 0);
        chk("t6_hit_data", q_rs_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
